ib_debounce_ctrl: RTL and testbench

IB_DEBOUNCE_CTRL -- requirements
Module: ib_debounce_ctrl

---
 rtl/ib_debounce_ctrl.sv | 152 +++++++++++++++
 tb/tb_ib_debounce_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ib_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module : ib_debounce_ctrl
// Debounces N_CH input-buffer pad levels and reports each qualified level
// change as a round-robin event on a valid/ready handshake.
// Rev    : 1.0  initial release
// ============================================================================
module ib_debounce_ctrl #(
    parameter int N_CH        = 8,
    parameter int DB_CYCLES   = 16,
    parameter bit RESET_LEVEL = 1'b0
) (
    input  logic                                      clk,
    input  logic                                      rst,
    input  logic [N_CH-1:0]                           pad_i,
    output logic [N_CH-1:0]                           level_o,
    output logic                                      ev_valid,
    input  logic                                      ev_ready,
    output logic [((N_CH > 1) ? $clog2(N_CH) : 1)-1:0] ev_ch,
    output logic                                      ev_level,
    output logic [N_CH-1:0]                           overrun_o,
    input  logic                                      overrun_clr
);

    localparam int               c_CHW     = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int               c_CW      = $clog2(DB_CYCLES) + 1;
    localparam logic [c_CW-1:0]  c_CNT_MAX = c_CW'(DB_CYCLES - 1);
    localparam logic [c_CHW:0]   c_NCH     = (c_CHW + 1)'(N_CH);
    localparam logic [c_CHW-1:0] c_LAST_CH = c_CHW'(N_CH - 1);
    localparam logic [N_CH-1:0]  c_RST_VEC = {N_CH{RESET_LEVEL}};

    typedef enum logic [0:0] {
        S_IDLE    = 1'b0,
        S_PRESENT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [N_CH-1:0]   sync1_q, sync2_q;
    logic [N_CH-1:0]   stable_q, stable_d;
    logic [N_CH-1:0]   pending_q, pending_d;
    logic [N_CH-1:0]   overrun_q, overrun_d;
    logic [N_CH-1:0]   toggle, clr;
    logic [c_CW-1:0]   cnt_q [N_CH];
    logic [c_CW-1:0]   cnt_d [N_CH];
    logic [c_CHW-1:0]  rr_q, rr_d;
    logic [c_CHW-1:0]  ev_ch_q, ev_ch_d;
    logic              ev_level_q, ev_level_d;
    logic              sel_found;
    logic [c_CHW-1:0]  sel_idx;
    logic [c_CHW:0]    cand;

    // A channel toggles after DB_CYCLES consecutive synced disagreements.
    always_comb begin
        toggle   = '0;
        stable_d = stable_q;
        for (int c = 0; c < N_CH; c++) begin
            cnt_d[c] = '0;
            if (sync2_q[c] != stable_q[c]) begin
                if (cnt_q[c] == c_CNT_MAX) begin
                    toggle[c]   = 1'b1;
                    stable_d[c] = ~stable_q[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + c_CW'(1);
                end
            end
        end
    end

    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = '0;
        for (int i = 0; i < N_CH; i++) begin
            cand = {1'b0, rr_q} + (c_CHW + 1)'(i);
            if (cand >= c_NCH) begin
                cand = cand - c_NCH;
            end
            if (!sel_found && pending_q[cand[c_CHW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[c_CHW-1:0];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        clr        = '0;
        rr_d       = rr_q;
        ev_ch_d    = ev_ch_q;
        ev_level_d = ev_level_q;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    clr[sel_idx] = 1'b1;
                    ev_ch_d      = sel_idx;
                    ev_level_d   = stable_q[sel_idx];
                    state_d      = S_PRESENT;
                end
            end
            S_PRESENT: begin
                if (ev_ready) begin
                    rr_d    = (ev_ch_q == c_LAST_CH) ? '0 : ev_ch_q + c_CHW'(1);
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        // A toggle landing on the cycle its pending bit is consumed is not a loss.
        pending_d = (pending_q & ~clr) | toggle;
        overrun_d = (overrun_clr ? '0 : overrun_q) | (toggle & pending_q & ~clr);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q    <= c_RST_VEC;
            sync2_q    <= c_RST_VEC;
            stable_q   <= c_RST_VEC;
            cnt_q      <= '{default: '0};
            pending_q  <= '0;
            overrun_q  <= '0;
            rr_q       <= '0;
            ev_ch_q    <= '0;
            ev_level_q <= 1'b0;
        end else begin
            sync1_q    <= pad_i;
            sync2_q    <= sync1_q;
            stable_q   <= stable_d;
            cnt_q      <= cnt_d;
            pending_q  <= pending_d;
            overrun_q  <= overrun_d;
            rr_q       <= rr_d;
            ev_ch_q    <= ev_ch_d;
            ev_level_q <= ev_level_d;
        end
    end

    assign level_o   = stable_q;
    assign ev_valid  = (state_q == S_PRESENT);
    assign ev_ch     = ev_ch_q;
    assign ev_level  = ev_level_q;
    assign overrun_o = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_ib_debounce_ctrl.sv
`default_nettype none
// ============================================================================
// Module : tb_ib_debounce_ctrl
// Directed bench for ib_debounce_ctrl with a window-based reference model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_ib_debounce_ctrl;

    localparam int N_CH = 8;
    localparam int DB   = 16;
    localparam bit RL   = 1'b0;
    localparam int CHW  = 3;

    logic            clk = 1'b0;
    logic            rst;
    logic [N_CH-1:0] pad;
    logic [N_CH-1:0] level;
    logic            ev_valid;
    logic            ev_ready;
    logic [CHW-1:0]  ev_ch;
    logic            ev_level;
    logic [N_CH-1:0] ovr;
    logic            ovr_clr;

    int n_chk = 0;
    int n_err = 0;
    int evq[$];

    always #5 clk = ~clk;

    ib_debounce_ctrl #(
        .N_CH        (N_CH),
        .DB_CYCLES   (DB),
        .RESET_LEVEL (RL)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pad_i       (pad),
        .level_o     (level),
        .ev_valid    (ev_valid),
        .ev_ready    (ev_ready),
        .ev_ch       (ev_ch),
        .ev_level    (ev_level),
        .overrun_o   (ovr),
        .overrun_clr (ovr_clr)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a level flips once the last DB synced samples all
    // disagree with it; events are served first-pending-from-pointer.
    logic [N_CH-1:0] m_s1, m_s2, m_stable, m_pend, m_ovr;
    logic [DB-1:0]   m_hist [N_CH];
    logic [N_CH-1:0] m_obs, m_tog;
    bit              m_busy, m_lvl, m_init = 1'b0, m_found;
    int              m_rr, m_ch, m_idx;

    always @(posedge clk) begin
        if (rst) begin
            m_s1 = {N_CH{RL}}; m_s2 = {N_CH{RL}}; m_stable = {N_CH{RL}};
            for (int c = 0; c < N_CH; c++) m_hist[c] = {DB{RL}};
            m_pend = '0; m_ovr = '0; m_rr = 0; m_busy = 1'b0; m_ch = 0; m_lvl = 1'b0;
            m_init = 1'b1;
        end else if (m_init) begin
            m_obs = m_s2; m_s2 = m_s1; m_s1 = pad;
            for (int c = 0; c < N_CH; c++) begin
                m_hist[c] = {m_hist[c][DB-2:0], m_obs[c]};
                m_tog[c]  = m_stable[c] ? (m_hist[c] == '0) : (&m_hist[c]);
            end
            if (!m_busy) begin
                m_found = 1'b0;
                for (int j = 0; j < N_CH; j++) begin
                    m_idx = (m_rr + j) % N_CH;
                    if (!m_found && m_pend[m_idx]) begin
                        m_found = 1'b1;
                        m_busy = 1'b1; m_ch = m_idx; m_lvl = m_stable[m_idx];
                        m_pend[m_idx] = 1'b0;
                    end
                end
            end else if (ev_ready) begin
                m_busy = 1'b0;
                m_rr = (m_ch + 1) % N_CH;
            end
            if (ovr_clr) m_ovr = '0;
            for (int c = 0; c < N_CH; c++) begin
                if (m_tog[c]) begin
                    if (m_pend[c]) m_ovr[c] = 1'b1;
                    m_pend[c] = 1'b1;
                end
            end
            m_stable = m_stable ^ m_tog;
        end
        #1;
        if (m_init) begin
            chk("mdl_level", int'(level), int'(m_stable));
            chk("mdl_valid", int'(ev_valid), int'(m_busy));
            chk("mdl_overrun", int'(ovr), int'(m_ovr));
            if (m_busy) begin
                chk("mdl_ev_ch", int'(ev_ch), m_ch);
                chk("mdl_ev_level", int'(ev_level), int'(m_lvl));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic step_n(input int n);
        repeat (n) step();
    endtask

    task automatic collect(input int n);
        evq.delete();
        repeat (n) begin
            if (ev_valid && ev_ready) evq.push_back(int'(ev_ch));
            step();
        end
    endtask

    task automatic wait_valid(input string name);
        int k = 0;
        while (!ev_valid && k < 40) begin
            step();
            k++;
        end
        chk(name, int'(ev_valid), 1);
    endtask

    int  vcnt;
    bit  hold_bad;

    initial begin
        rst = 1'b1; pad = '0; ev_ready = 1'b0; ovr_clr = 1'b0;
        step_n(3);
        rst = 1'b0;
        chk("rst_level", int'(level), 0);
        chk("rst_valid", int'(ev_valid), 0);
        chk("rst_overrun", int'(ovr), 0);
        chk("rst_ev_ch", int'(ev_ch), 0);

        // Held edge on ch2: level at edge 18, event visible after edge 19.
        pad[2] = 1'b1;
        step_n(17);
        chk("ch2_level_e17", int'(level[2]), 0);
        step();
        chk("ch2_level_e18", int'(level[2]), 1);
        chk("ch2_valid_e18", int'(ev_valid), 0);
        step();
        chk("ch2_valid_e19", int'(ev_valid), 1);
        chk("ch2_ev_ch", int'(ev_ch), 2);
        chk("ch2_ev_level", int'(ev_level), 1);
        ev_ready = 1'b1;
        step();
        chk("ch2_valid_after_hs", int'(ev_valid), 0);

        // 15-cycle glitch is rejected; 16-cycle pulse qualifies.
        pad[0] = 1'b1;
        step_n(15);
        pad[0] = 1'b0;
        vcnt = 0;
        repeat (40) begin
            if (ev_valid) vcnt++;
            step();
        end
        chk("glitch15_level", int'(level[0]), 0);
        chk("glitch15_events", vcnt, 0);
        pad[0] = 1'b1;
        step_n(16);
        pad[0] = 1'b0;
        step_n(2);
        chk("pulse16_level", int'(level[0]), 1);
        step_n(40);
        chk("pulse16_back", int'(level[0]), 0);

        // Simultaneous toggles served round-robin.
        pad = pad | 8'b0110_0010;
        collect(40);
        chk("rr1_count", evq.size(), 3);
        if (evq.size() == 3) begin
            chk("rr1_first", evq[0], 1);
            chk("rr1_second", evq[1], 5);
            chk("rr1_third", evq[2], 6);
        end
        pad = pad & ~8'b0010_0010;
        collect(40);
        chk("rr2_count", evq.size(), 2);
        if (evq.size() == 2) begin
            chk("rr2_first", evq[0], 1);
            chk("rr2_second", evq[1], 5);
        end

        // Stalled ch3 event while ch4 toggles twice.
        ev_ready = 1'b0;
        pad[3] = 1'b1;
        wait_valid("ch3_valid");
        chk("ch3_ev_ch", int'(ev_ch), 3);
        pad[4] = 1'b1;
        hold_bad = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (i == 30) pad[4] = 1'b0;
            if (!ev_valid || ev_ch != 3'd3 || !ev_level) hold_bad = 1'b1;
            step();
        end
        chk("ch3_hold_stable", int'(hold_bad), 0);
        chk("ch4_overrun", int'(ovr[4]), 1);
        ovr_clr = 1'b1;
        step();
        ovr_clr = 1'b0;
        chk("overrun_cleared", int'(ovr), 0);
        ev_ready = 1'b1;
        collect(20);
        chk("drain_count", evq.size(), 2);
        if (evq.size() == 2) begin
            chk("drain_first", evq[0], 3);
            chk("drain_second", evq[1], 4);
        end

        // Reset during a presented event discards it.
        ev_ready = 1'b0;
        pad[7] = 1'b1;
        wait_valid("ch7_valid");
        chk("ch7_ev_ch", int'(ev_ch), 7);
        rst = 1'b1;
        pad = '0;
        step();
        rst = 1'b0;
        chk("rst_drops_valid", int'(ev_valid), 0);
        chk("rst_level_all", int'(level), 0);
        chk("rst_ev_ch_zero", int'(ev_ch), 0);
        ev_ready = 1'b1;
        vcnt = 0;
        repeat (60) begin
            if (ev_valid) vcnt++;
            step();
        end
        chk("post_rst_events", vcnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
`default_nettype wire
